// File: rtl/rom_ref_error_gen.sv
// ROM-reference error generator.
// On each accepted sample tick, reads the next reference sample from an
// external synchronous ROM and presents e = vref - rom_data (saturated to
// OUT_W signed bits) over a valid/ready handshake.
//
// Ports:
//   clk, Rst_n        clock, asynchronous active-low reset
//   fs_tick           one-cycle sample strobe
//   enable            run request; low returns to IDLE and clears flags
//   one_shot, tab_len run mode and last table address, latched on IDLE->RUN
//   vref              reference offset, latched on each accepted tick
//   rom_addr          registered ROM address
//   rom_data          ROM read data, valid ROM_LAT cycles after the address
//   e_data, e_valid   signed error and its valid (held until e_ready)
//   e_ready           downstream accept
//   wrap              pulse on first e_valid cycle of the sample at tab_len
//   done              one-shot pass complete (level)
//   overrun           sticky: a tick arrived while a sample was in flight
module rom_ref_error_gen #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned OUT_W   = 13
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              fs_tick,
    input  logic              enable,
    input  logic              one_shot,
    input  logic [ADDR_W-1:0] tab_len,
    input  logic [DATA_W-1:0] vref,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [OUT_W-1:0]  e_data,
    output logic              e_valid,
    input  logic              e_ready,
    output logic              wrap,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned DIFF_W = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                one_shot_q, one_shot_d;
    logic [ADDR_W-1:0]   tab_len_q, tab_len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   vref_q, vref_d;
    logic [ROM_LAT-1:0]  pipe_q, pipe_d;
    logic                last_q, last_d;
    logic                cap_vld_q, cap_vld_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [OUT_W-1:0]    e_data_q, e_data_d;
    logic                e_valid_q, e_valid_d;
    logic                wrap_q, wrap_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                busy_c;
    logic                xfer_c;
    logic                finish_c;
    logic                tick_c;
    logic                accept_c;
    logic                at_end_c;
    logic signed [DIFF_W-1:0] diff_c;
    logic [OUT_W-1:0]    sat_c;

    // Elaboration-time guard on the supported ROM latency range.
    generate
        if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
            $error("rom_ref_error_gen: ROM_LAT must be 1..4");
        end
    endgenerate

    // Signed difference of two unsigned samples, one guard bit wide.
    assign diff_c = $signed({1'b0, vref_q}) - $signed({1'b0, cap_q});

    // Sign-extend when the output is wide enough, otherwise clamp.
    generate
        if (OUT_W >= DIFF_W) begin : g_ext
            assign sat_c = OUT_W'(diff_c);
        end else begin : g_sat
            localparam logic signed [DIFF_W-1:0] SAT_MAX =
                DIFF_W'((64'd1 << (OUT_W - 1)) - 64'd1);
            localparam logic signed [DIFF_W-1:0] SAT_MIN = ~SAT_MAX;
            always_comb begin
                sat_c = OUT_W'(diff_c);
                if (diff_c > SAT_MAX) begin
                    sat_c = OUT_W'(SAT_MAX);
                end else if (diff_c < SAT_MIN) begin
                    sat_c = OUT_W'(SAT_MIN);
                end
            end
        end
    endgenerate

    // A sample is in flight from its tick until its transfer; the transfer
    // cycle itself is free so back-to-back ticks at the minimum spacing work.
    assign busy_c   = (|pipe_q) | cap_vld_q | (e_valid_q & ~e_ready);
    assign xfer_c   = e_valid_q & e_ready;
    // The final one-shot transfer closes the pass; a tick on that cycle is
    // ignored so nothing starts or advances on the way into DONE.
    assign finish_c = (state_q == ST_RUN) & one_shot_q & xfer_c & last_q;
    assign tick_c   = fs_tick & (state_q == ST_RUN) & ~finish_c;
    assign accept_c = tick_c & ~busy_c;
    assign at_end_c = (addr_q == tab_len_q);

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        one_shot_d = one_shot_q;
        tab_len_d  = tab_len_q;
        addr_d     = addr_q;
        vref_d     = vref_q;
        pipe_d     = '0;
        last_d     = last_q;
        cap_vld_d  = pipe_q[ROM_LAT-1];
        cap_d      = cap_q;
        e_data_d   = e_data_q;
        e_valid_d  = e_valid_q;
        wrap_d     = 1'b0;
        done_d     = done_q;
        overrun_d  = overrun_q;

        // Tick tracker: one bit walks ROM_LAT stages alongside the ROM read.
        pipe_d[0] = accept_c;
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (pipe_q[ROM_LAT-1]) begin
            cap_d = rom_data;
        end

        if (xfer_c) begin
            e_valid_d = 1'b0;
        end
        if (cap_vld_q) begin
            e_valid_d = 1'b1;
            e_data_d  = sat_c;
            wrap_d    = last_q;
        end

        if (accept_c) begin
            vref_d = vref;
            last_d = at_end_c;
        end

        // Every tick in RUN advances the address, dropped or not, so the
        // table stays aligned with sample time.
        if (tick_c) begin
            if (busy_c) begin
                overrun_d = 1'b1;
            end
            addr_d = at_end_c ? '0 : addr_q + ADDR_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_RUN;
                    one_shot_d = one_shot;
                    tab_len_d  = tab_len;
                end
            end
            ST_RUN: begin
                if (finish_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);

        // Dropping enable aborts everything on the same cycle.
        if (!enable) begin
            state_d   = ST_IDLE;
            addr_d    = '0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
            pipe_d    = '0;
            cap_vld_d = 1'b0;
            e_valid_d = 1'b0;
            wrap_d    = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            one_shot_q <= 1'b0;
            tab_len_q  <= '0;
            addr_q     <= '0;
            vref_q     <= '0;
            pipe_q     <= '0;
            last_q     <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_q      <= '0;
            e_data_q   <= '0;
            e_valid_q  <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            one_shot_q <= one_shot_d;
            tab_len_q  <= tab_len_d;
            addr_q     <= addr_d;
            vref_q     <= vref_d;
            pipe_q     <= pipe_d;
            last_q     <= last_d;
            cap_vld_q  <= cap_vld_d;
            cap_q      <= cap_d;
            e_data_q   <= e_data_d;
            e_valid_q  <= e_valid_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_addr = addr_q;
    assign e_data   = e_data_q;
    assign e_valid  = e_valid_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_rom_ref_error_gen.sv
// Bench for rom_ref_error_gen: two instances (ROM_LAT=1/OUT_W=13 and
// ROM_LAT=3/OUT_W=8) share stimulus; each has its own ROM and its own
// transaction-level reference model.
module tb_rom_ref_error_gen;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LAT_A  = 1;
    localparam int unsigned OUTW_A = 13;
    localparam int unsigned LAT_B  = 3;
    localparam int unsigned OUTW_B = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              fs_tick = 1'b0;
    logic              enable = 1'b0;
    logic              one_shot = 1'b0;
    logic              e_ready = 1'b0;
    logic [ADDR_W-1:0] tab_len = '0;
    logic [DATA_W-1:0] vref = '0;

    logic [ADDR_W-1:0] rom_addr_a, rom_addr_b;
    logic [DATA_W-1:0] rom_data_a, rom_data_b;
    logic [OUTW_A-1:0] e_data_a;
    logic [OUTW_B-1:0] e_data_b;
    logic              e_valid_a, e_valid_b, wrap_a, wrap_b;
    logic              done_a, done_b, overrun_a, overrun_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rom_ref_error_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROM_LAT(LAT_A), .OUT_W(OUTW_A)) dut_a (
        .clk(clk), .Rst_n(Rst_n), .fs_tick(fs_tick), .enable(enable), .one_shot(one_shot),
        .tab_len(tab_len), .vref(vref), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .e_data(e_data_a), .e_valid(e_valid_a), .e_ready(e_ready), .wrap(wrap_a),
        .done(done_a), .overrun(overrun_a));

    rom_ref_error_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROM_LAT(LAT_B), .OUT_W(OUTW_B)) dut_b (
        .clk(clk), .Rst_n(Rst_n), .fs_tick(fs_tick), .enable(enable), .one_shot(one_shot),
        .tab_len(tab_len), .vref(vref), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .e_data(e_data_b), .e_valid(e_valid_b), .e_ready(e_ready), .wrap(wrap_b),
        .done(done_b), .overrun(overrun_b));

    // External ROMs: the address seen at an edge appears ROM_LAT edges later.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a [LAT_A];
    logic [DATA_W-1:0] rd_b [LAT_B];

    always @(posedge clk) begin
        rd_a[0] <= mem[rom_addr_a];
        for (int i = 1; i < int'(LAT_A); i++) rd_a[i] <= rd_a[i-1];
        rd_b[0] <= mem[rom_addr_b];
        for (int i = 1; i < int'(LAT_B); i++) rd_b[i] <= rd_b[i-1];
    end
    assign rom_data_a = rd_a[LAT_A-1];
    assign rom_data_b = rd_b[LAT_B-1];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (index 0 = A, 1 = B) ----------------
    int cyc = 0;
    int m_lat [2] = '{int'(LAT_A), int'(LAT_B)};
    int m_w   [2] = '{int'(OUTW_A), int'(OUTW_B)};
    int m_st  [2] = '{0, 0};   // 0 idle, 1 run, 2 done
    int m_addr[2] = '{0, 0};
    int m_len [2] = '{0, 0};
    int m_os  [2] = '{0, 0};
    int m_ovr [2] = '{0, 0};
    int m_infl[2] = '{0, 0};
    int m_due [2] = '{0, 0};
    int m_pval[2] = '{0, 0};
    int m_plst[2] = '{0, 0};
    int m_ov  [2] = '{0, 0};
    int m_od  [2] = '{0, 0};
    int m_olst[2] = '{0, 0};
    int m_wrap[2] = '{0, 0};

    function automatic int sat(input int d, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        return (d > hi) ? hi : ((d < lo) ? lo : d);
    endfunction

    task automatic model_step(input int k);
        int busy, xfer, fin;
        if (!enable) begin
            m_st[k] = 0; m_addr[k] = 0; m_ovr[k] = 0; m_infl[k] = 0;
            m_ov[k] = 0; m_wrap[k] = 0;
            return;
        end
        m_wrap[k] = 0;
        case (m_st[k])
            0: begin
                m_st[k] = 1; m_len[k] = int'(tab_len); m_os[k] = int'(one_shot);
            end
            1: begin
                busy = (m_infl[k] != 0 || (m_ov[k] != 0 && !e_ready)) ? 1 : 0;
                xfer = (m_ov[k] != 0 && e_ready) ? 1 : 0;
                fin  = (xfer != 0 && m_os[k] != 0 && m_olst[k] != 0) ? 1 : 0;
                if (xfer != 0) m_ov[k] = 0;
                if (m_infl[k] != 0 && cyc == m_due[k]) begin
                    m_ov[k] = 1; m_od[k] = m_pval[k]; m_wrap[k] = m_plst[k];
                    m_olst[k] = m_plst[k]; m_infl[k] = 0;
                end
                if (fs_tick && fin == 0) begin
                    if (busy != 0) m_ovr[k] = 1;
                    else begin
                        m_infl[k] = 1;
                        m_due[k]  = cyc + m_lat[k] + 1;
                        m_pval[k] = sat(int'(vref) - int'(mem[m_addr[k]]), m_w[k]);
                        m_plst[k] = (m_addr[k] == m_len[k]) ? 1 : 0;
                    end
                    m_addr[k] = (m_addr[k] == m_len[k]) ? 0 : m_addr[k] + 1;
                end
                if (fin != 0) m_st[k] = 2;
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_addr[k] = 0; m_ovr[k] = 0; m_infl[k] = 0;
                m_ov[k] = 0; m_od[k] = 0; m_wrap[k] = 0; m_olst[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("A.valid", int'(e_valid_a), m_ov[0]);
            if (m_ov[0] != 0) check_eq("A.data", int'($signed(e_data_a)), m_od[0]);
            check_eq("A.wrap", int'(wrap_a), m_wrap[0]);
            check_eq("A.done", int'(done_a), (m_st[0] == 2) ? 1 : 0);
            check_eq("A.overrun", int'(overrun_a), m_ovr[0]);
            check_eq("A.addr", int'(rom_addr_a), m_addr[0]);
            check_eq("B.valid", int'(e_valid_b), m_ov[1]);
            if (m_ov[1] != 0) check_eq("B.data", int'($signed(e_data_b)), m_od[1]);
            check_eq("B.wrap", int'(wrap_b), m_wrap[1]);
            check_eq("B.done", int'(done_b), (m_st[1] == 2) ? 1 : 0);
            check_eq("B.overrun", int'(overrun_b), m_ovr[1]);
            check_eq("B.addr", int'(rom_addr_b), m_addr[1]);
        end
    end

    // Transfer recorder for instance A used by the directed checks.
    bit rec = 1'b0;
    int q_a[$];
    int xfer_cnt = 0;
    int wrap_val = 0;
    always @(negedge clk) begin
        if (rec && e_valid_a && e_ready) begin
            q_a.push_back(int'($signed(e_data_a)));
            xfer_cnt++;
        end
        if (rec && wrap_a) wrap_val = int'($signed(e_data_a));
    end

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) fs_tick = 1'b1;
            @(negedge clk) fs_tick = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    task automatic restart(input bit os, input int len);
        @(negedge clk) enable = 1'b0;
        one_shot = os;
        tab_len  = ADDR_W'(len);
        @(negedge clk) enable = 1'b1;
    endtask

    initial begin
        int exp1 [8] = '{2000, 1000, 0, -2095, 2000, 1000, 0, -2095};
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'($urandom);
        mem[0] = 12'd0; mem[1] = 12'd1000; mem[2] = 12'd2000; mem[3] = 12'd4095;

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst.addr", int'(rom_addr_a), 0);
        check_eq("rst.valid", int'(e_valid_b), 0);
        check_eq("rst.data", int'(e_data_a), 0);
        check_eq("rst.flags", int'({wrap_a, done_a, overrun_a, wrap_b, done_b, overrun_b}), 0);
        Rst_n = 1'b1;
        chk_en = 1'b1;

        // Continuous pass over a 4-entry table.
        vref = 12'd2000; e_ready = 1'b1;
        restart(1'b0, 3);
        rec = 1'b1;
        ticks(8, 8);
        repeat (6) @(negedge clk);
        rec = 1'b0;
        check_eq("cont.count", q_a.size(), 8);
        for (int i = 0; i < 8 && i < q_a.size(); i++) check_eq("cont.seq", q_a[i], exp1[i]);
        check_eq("cont.wrapval", wrap_val, -2095);

        // One-shot pass: four transfers then done; later ticks do nothing.
        restart(1'b1, 3);
        xfer_cnt = 0; rec = 1'b1;
        ticks(8, 8);
        repeat (6) @(negedge clk);
        rec = 1'b0;
        check_eq("oneshot.count", xfer_cnt, 4);
        check_eq("oneshot.done", int'(done_a & done_b), 1);
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        check_eq("oneshot.clr", int'({done_a, done_b}), 0);
        check_eq("oneshot.addr", int'(rom_addr_b), 0);

        // Stalled consumer across two extra ticks.
        e_ready = 1'b0;
        restart(1'b0, 3);
        ticks(3, 8);
        check_eq("stall.data", int'($signed(e_data_a)), 2000);
        check_eq("stall.ovr", int'(overrun_a & overrun_b), 1);
        check_eq("stall.addr", int'(rom_addr_a), 3);
        xfer_cnt = 0; rec = 1'b1;
        @(negedge clk) e_ready = 1'b1;
        repeat (10) @(negedge clk);
        rec = 1'b0;
        check_eq("stall.release", xfer_cnt, 1);

        // Saturation of the 8-bit instance at both ends.
        vref = 12'd4095;
        restart(1'b0, 0);
        ticks(1, 8);
        check_eq("sat.hi", int'($signed(e_data_b)), 127);
        check_eq("sat.hi_wide", int'($signed(e_data_a)), 4095);
        vref = 12'd0;
        restart(1'b0, 3);
        ticks(4, 8);
        check_eq("sat.lo", int'($signed(e_data_b)), -128);
        check_eq("sat.lo_wide", int'($signed(e_data_a)), -4095);

        // Tick spacing against ROM latency.
        vref = 12'd1234;
        restart(1'b0, 7);
        ticks(6, 5);
        check_eq("space5.ovr", int'(overrun_b), 0);
        ticks(6, 3);
        check_eq("space3.ovrB", int'(overrun_b), 1);
        check_eq("space3.ovrA", int'(overrun_a), 0);

        // Asynchronous reset in the middle of the pipeline.
        restart(1'b0, 3);
        ticks(1, 2);
        @(posedge clk) #2 Rst_n = 1'b0;
        #1;
        check_eq("arst.a", int'({e_valid_a, wrap_a, done_a, overrun_a}), 0);
        check_eq("arst.b", int'({e_valid_b, wrap_b, done_b, overrun_b}), 0);
        check_eq("arst.data", int'(e_data_b) + int'(e_data_a), 0);
        check_eq("arst.addr", int'(rom_addr_a) + int'(rom_addr_b), 0);
        @(negedge clk) Rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Randomized operation.
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            fs_tick = ($urandom_range(0, 3) == 0);
            e_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) vref = DATA_W'($urandom);
            if ($urandom_range(0, 40) == 0) tab_len = ADDR_W'($urandom_range(0, 7));
            if ($urandom_range(0, 250) == 0) begin
                enable   = 1'b0;
                one_shot = ($urandom_range(0, 2) == 0);
            end else begin
                enable = 1'b1;
            end
        end
        fs_tick = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_ref_error_gen.md
Name: rom_ref_error_gen

Overview:
- Parametrised successor of the ROM-reference error stage in the control loop.
- On each sample tick it reads the next reference sample from an external synchronous ROM and forms the signed integer error e = vref - rom_data.
- It presents the error to the downstream controller over a valid/ready handshake.
- Adds programmable table length, one-shot/continuous modes, a configurable ROM read latency, output saturation and overrun detection.

Parameters:
- DATA_W, 12: ROM sample and vref width (unsigned).
- ADDR_W, 10: ROM address width.
- ROM_LAT, 1: ROM read latency in clk cycles (1..4).
- OUT_W, 13: signed error width. Saturates when OUT_W < DATA_W+1.

Ports:
- clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- fs_tick  in  1  one-cycle sample strobe, synchronous to clk.
- enable  in  1  run request. Low returns the block to IDLE and clears flags.
- one_shot  in  1  1: stop after one table pass. 0: wrap continuously. Sampled on the IDLE->RUN transition.
- tab_len  in  ADDR_W  last valid table address. Sampled on the IDLE->RUN transition.
- vref  in  DATA_W  reference offset, latched on each accepted fs_tick.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after the address.
- e_data  out  OUT_W  signed error.
- e_valid  out  1  error valid. Held until accepted.
- e_ready  in  1  downstream accept.
- wrap  out  1  one-cycle pulse, coincident with the first e_valid cycle of the sample at address tab_len.
- done  out  1  one-shot pass complete (level).
- overrun  out  1  sticky: a sample was dropped.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE, rom_addr=0, e_data=0, e_valid=0, wrap=0, done=0, overrun=0, pipeline flushed.
- States:
  - IDLE -> RUN when enable=1 (one_shot and tab_len latched).
  - RUN -> DONE when one_shot=1 and the sample at tab_len has been accepted (e_valid & e_ready).
  - RUN/DONE -> IDLE whenever enable=0, on the same cycle: rom_addr=0, done=0, overrun=0, in-flight sample discarded, e_valid=0.
- Accepted tick: fs_tick=1 in RUN with no sample in flight.
  - Accepted tick at cycle t: vref latched at t; rom_data captured at t+ROM_LAT; e_data/e_valid registered at t+ROM_LAT+1.
  - Latency from tick to e_valid = ROM_LAT+1 cycles.
  - rom_addr advances at t+1: addr+1, or 0 if addr==tab_len.
- In flight: from the accepted tick until e_valid & e_ready.
- Overrun: fs_tick while a sample is in flight (pipeline busy or e_valid held by e_ready=0).
  - Sets overrun.
  - The tick is dropped but rom_addr still advances, preserving time alignment with the table.
  - e_data holds the older sample.
- fs_tick is ignored in IDLE and DONE. Address wrap in DONE never happens.
- Arithmetic: diff = {0,vref} - {0,rom_data}, computed in DATA_W+1 signed bits.
  - If OUT_W >= DATA_W+1: sign-extend.
  - Else clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Handshake:
  - e_valid stays high and e_data stable until e_ready=1. The transfer occurs on the cycle with e_valid & e_ready.
  - e_valid drops the next cycle unless a new result lands the same cycle.
- wrap pulses once per pass even if e_valid is held. done asserts the cycle after the final transfer in one-shot mode.
- tab_len=0: every sample reads address 0. wrap pulses on every sample.
- tab_len and one_shot changes while in RUN have no effect until the next IDLE->RUN.

Test Plan:
- ROM_LAT=1, tab_len=3, continuous, vref=2000, ROM[0..3]={0,1000,2000,4095}, ticks every 8 cycles, e_ready=1 -> e_data = 2000, 1000, 0, -2095, 2000, ... Each e_valid arrives 2 cycles after its tick. wrap coincides with the -2095 sample.
- one_shot=1, tab_len=3 -> exactly 4 transfers, then done=1. Further ticks produce no e_valid. Dropping enable clears done and sets rom_addr=0.
- e_ready held 0 across 2 ticks -> first e_data held stable, overrun=1, rom_addr advanced by 2. Releasing e_ready gives one transfer of the held value.
- OUT_W=8, vref=4095, rom=0 -> e_data=127. vref=0, rom=4095 -> e_data=-128.
- Rst_n pulsed low mid-pipeline (between tick and e_valid) -> all outputs 0 immediately. No e_valid after release until enable=1 and a new tick.
- ROM_LAT=3, tick spacing 3 cycles -> every second tick flagged as overrun. Spacing 5 -> no overrun, latency 4 cycles.
